// File: rtl/jtag_host_shifter.sv
// JTAG host shifter: walks the TAP from Run-Test/Idle through one IR or DR scan of 1..16 bits.
// Optional macro JTAG_HOST_TLR_CMD_EN adds a cmdTlr input that replays the Test-Logic-Reset walk.
module jtag_host_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic        cmdIsIr,
    input  logic [3:0]  cmdLen,
    input  logic [15:0] cmdData,
`ifdef JTAG_HOST_TLR_CMD_EN
    input  logic        cmdTlr,
`endif
    output logic        rspValid,
    output logic [15:0] rspData,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
    localparam logic [CW-1:0] WRAP = CW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_POST
    } state_t;

    state_t        state_q;
    logic [CW-1:0] tcnt_q;
    logic [3:0]    idx_q;
    logic          ir_q;
    logic [3:0]    len_q;
    logic [15:0]   data_q;
    logic [15:0]   cap_data_q;
    logic          cap_q;
    logic [3:0]    cap_idx_q;
    logic          tlr_q;
    logic          tck_q;
    logic          tms_q;
    logic          tdi_q;
    logic          ready_q;
    logic          busy_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_data_q;

    logic          accept;
    logic          tlr_req;

`ifdef JTAG_HOST_TLR_CMD_EN
    assign tlr_req = cmdTlr;
`else
    assign tlr_req = 1'b0;
`endif

    assign accept = cmdValid && ready_q;

    // tcnt_q==0 marks the edge that opens a TCK low phase, tcnt_q==HALF the rising edge.
    // Each state advances on its low-phase edges; the edge after the last TCK returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            tcnt_q      <= '0;
            idx_q       <= '0;
            ir_q        <= 1'b0;
            len_q       <= '0;
            data_q      <= '0;
            cap_data_q  <= '0;
            cap_q       <= 1'b0;
            cap_idx_q   <= '0;
            tlr_q       <= 1'b0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (accept) begin
                    ir_q       <= cmdIsIr;
                    len_q      <= cmdLen;
                    data_q     <= cmdData;
                    tlr_q      <= tlr_req;
                    cap_data_q <= '0;
                    idx_q      <= '0;
                    tcnt_q     <= '0;
                    state_q    <= tlr_req ? S_INIT : S_PRE;
                    ready_q    <= 1'b0;
                    busy_q     <= 1'b1;
                end
            end else begin
                tcnt_q <= (tcnt_q == WRAP) ? '0 : tcnt_q + CW'(1);
                if (tcnt_q == HALF) begin
                    tck_q <= 1'b1;
                    if (cap_q) begin
                        cap_data_q[cap_idx_q] <= tdo;
                    end
                end else if (tcnt_q == '0) begin
                    tck_q <= 1'b0;
                    tdi_q <= 1'b0;
                    cap_q <= 1'b0;
                    idx_q <= idx_q + 4'd1;
                    case (state_q)
                        S_INIT: begin
                            if (idx_q == 4'd6) begin
                                state_q <= S_IDLE;
                                tms_q   <= 1'b0;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                tcnt_q  <= '0;
                                if (tlr_q) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= '0;
                                end
                            end else begin
                                tms_q <= (idx_q < 4'd5);
                            end
                        end
                        S_PRE: begin
                            tms_q <= (idx_q == 4'd0) || (ir_q && idx_q == 4'd1);
                            if (idx_q == (ir_q ? 4'd3 : 4'd2)) begin
                                state_q <= S_SHIFT;
                                idx_q   <= '0;
                            end
                        end
                        S_SHIFT: begin
                            tms_q     <= (idx_q == len_q);
                            tdi_q     <= data_q[idx_q];
                            cap_q     <= 1'b1;
                            cap_idx_q <= idx_q;
                            if (idx_q == len_q) begin
                                state_q <= S_POST;
                                idx_q   <= '0;
                            end
                        end
                        S_POST: begin
                            if (idx_q == 4'd2) begin
                                state_q     <= S_IDLE;
                                tms_q       <= 1'b0;
                                ready_q     <= 1'b1;
                                busy_q      <= 1'b0;
                                tcnt_q      <= '0;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= cap_data_q;
                            end else begin
                                tms_q <= (idx_q == 4'd0);
                            end
                        end
                        default: begin
                            state_q <= S_INIT;
                        end
                    endcase
                end
            end
        end
    end

    assign cmdReady = ready_q;
    assign busy     = busy_q;
    assign rspValid = rsp_valid_q;
    assign rspData  = rsp_data_q;
    assign tck      = tck_q;
    assign tms      = tms_q;
    assign tdi      = tdi_q;

endmodule
